// File: rtl/ps2_move_scheduler.sv
// PS/2 set-2 scancode parser and frame-synchronised move scheduler with typematic repeat.
// Optional macro PS2_MOVE_WASD_EN adds non-extended W/A/S/D as aliases of the arrow keys.
module ps2_move_scheduler #(
  parameter int unsigned REPEAT_DELAY = 15,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  input  logic       frame_tick,
  input  logic       enable,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] held
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  localparam logic [6:0] DelayLim = 7'(REPEAT_DELAY);
  localparam logic [6:0] RateLim  = 7'(REPEAT_RATE);

  state_e     state_q, state_d;
  logic [3:0] held_q, held_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] phase_q, phase_d;  // 0: waiting out the first delay, 1: repeating at rate
  logic [5:0] cnt_q [4];
  logic [5:0] cnt_d [4];
  logic [3:0] make_ev, brk_ev;
  logic [3:0] fire, out_fire;
  logic [3:0] move_q, move_d;
  logic [6:0] lim, cnt_inc;

  // Direction bit order matches the held output: {right, left, down, up}.
  function automatic logic [3:0] arrow_dir(input logic [7:0] b);
    case (b)
      8'h75:   arrow_dir = 4'b0001;
      8'h72:   arrow_dir = 4'b0010;
      8'h6B:   arrow_dir = 4'b0100;
      8'h74:   arrow_dir = 4'b1000;
      default: arrow_dir = 4'b0000;
    endcase
  endfunction

`ifdef PS2_MOVE_WASD_EN
  function automatic logic [3:0] wasd_dir(input logic [7:0] b);
    case (b)
      8'h1D:   wasd_dir = 4'b0001;
      8'h1B:   wasd_dir = 4'b0010;
      8'h1C:   wasd_dir = 4'b0100;
      8'h23:   wasd_dir = 4'b1000;
      default: wasd_dir = 4'b0000;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    make_ev = 4'b0000;
    brk_ev  = 4'b0000;
    if (key_valid) begin
      unique case (state_q)
        StIdle: begin
          if (key_data == 8'hE0)      state_d = StExt;
          else if (key_data == 8'hF0) state_d = StBrk;
          else begin
            state_d = StIdle;
`ifdef PS2_MOVE_WASD_EN
            make_ev = wasd_dir(key_data);
`endif
          end
        end
        StExt: begin
          if (key_data == 8'hF0)      state_d = StExtBrk;
          else if (key_data == 8'hE0) state_d = StExt;
          else begin
            make_ev = arrow_dir(key_data);
            state_d = StIdle;
          end
        end
        StBrk: begin
          state_d = StIdle;
`ifdef PS2_MOVE_WASD_EN
          brk_ev  = wasd_dir(key_data);
`endif
        end
        StExtBrk: begin
          brk_ev  = arrow_dir(key_data);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Tick update is computed from pre-key state; a key event in the same cycle overrides it,
  // so the key only influences the following tick.
  always_comb begin
    held_d  = held_q;
    pend_d  = pend_q;
    phase_d = phase_q;
    fire    = 4'b0000;
    lim     = DelayLim;
    cnt_inc = 7'd0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frame_tick) begin
        lim     = phase_q[i] ? RateLim : DelayLim;
        cnt_inc = {1'b0, cnt_q[i]} + 7'd1;
        if (pend_q[i]) begin
          fire[i]    = 1'b1;
          pend_d[i]  = 1'b0;
          cnt_d[i]   = 6'd0;
          phase_d[i] = 1'b0;
        end else if (held_q[i]) begin
          if (cnt_inc >= lim) begin
            fire[i]    = 1'b1;
            cnt_d[i]   = 6'd0;
            phase_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_inc[5:0];
          end
        end else begin
          cnt_d[i]   = 6'd0;
          phase_d[i] = 1'b0;
        end
      end
      if (make_ev[i] && !held_q[i]) begin
        held_d[i]  = 1'b1;
        pend_d[i]  = 1'b1;
        cnt_d[i]   = 6'd0;
        phase_d[i] = 1'b0;
      end
      if (brk_ev[i]) held_d[i] = 1'b0;
    end
  end

  // Opposing fires cancel at the output only; internal state already advanced above.
  always_comb begin
    out_fire = fire & {4{enable}};
    if (fire[0] && fire[1]) out_fire[1:0] = 2'b00;
    if (fire[2] && fire[3]) out_fire[3:2] = 2'b00;
    move_d = out_fire;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      held_q  <= 4'b0000;
      pend_q  <= 4'b0000;
      phase_q <= 4'b0000;
      move_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 6'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
      phase_q <= phase_d;
      move_q  <= move_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];
  assign held       = held_q;

endmodule

// File: tb/tb_ps2_move_scheduler.sv
// Bench for ps2_move_scheduler: sequence-level key/repeat model checked every cycle,
// plus literal pulse schedules for the directed scenarios.
`timescale 1ns/1ps
module tb_ps2_move_scheduler;

  localparam int Delay = 15;
  localparam int Rate  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_data;
  logic       frame_tick;
  logic       enable;
  logic       move_up, move_down, move_left, move_right;
  logic [3:0] held;

  ps2_move_scheduler #(.REPEAT_DELAY(Delay), .REPEAT_RATE(Rate)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .frame_tick (frame_tick),
    .enable     (enable),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .held       (held)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int misc    = 0;
  int tick_no = 0;
  logic check_en = 1'b0;
  logic [3:0] exp_move = 4'b0, exp_held = 4'b0, nxt_move;
  int hits_up[$], hits_down[$], hits_left[$], hits_right[$];

  // Model: held keys, untaken taps, frames since last move, moves issued while held.
  logic [3:0] m_held = 4'b0, m_pend = 4'b0;
  int m_age [4];
  int m_reps[4];
  logic [7:0] m_seq[$];

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_idx(input logic [7:0] b);
`ifdef PS2_MOVE_WASD_EN
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
`else
    if (b == 8'hxx) return -2;
    return -1;
`endif
  endfunction

  task automatic model_reset();
    m_held = 4'b0;
    m_pend = 4'b0;
    for (int i = 0; i < 4; i++) begin m_age[i] = 0; m_reps[i] = 0; end
    m_seq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic t);
    logic [3:0] f;
    int dir;
    logic mk;
    f = 4'b0;
    if (t) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          f[i] = 1'b1; m_pend[i] = 1'b0; m_age[i] = 0; m_reps[i] = 0;
        end else if (m_held[i]) begin
          m_age[i]++;
          if (m_age[i] == ((m_reps[i] == 0) ? Delay : Rate)) begin
            f[i] = 1'b1; m_age[i] = 0; m_reps[i]++;
          end
        end else begin
          m_age[i] = 0; m_reps[i] = 0;
        end
      end
      if (f[0] && f[1]) f[1:0] = 2'b00;
      if (f[2] && f[3]) f[3:2] = 2'b00;
      if (!enable) f = 4'b0;
    end
    nxt_move = f;
    if (v) begin
      m_seq.push_back(d);
      dir = -1;
      mk  = 1'b0;
      if (m_seq.size() == 2 && m_seq[0] == 8'hE0 && m_seq[1] == 8'hE0) begin
        void'(m_seq.pop_back());
      end else if (!((m_seq.size() == 1 && (d == 8'hE0 || d == 8'hF0)) ||
                     (m_seq.size() == 2 && m_seq[0] == 8'hE0 && m_seq[1] == 8'hF0))) begin
        if (m_seq.size() == 1) begin dir = wasd_idx(m_seq[0]); mk = 1'b1; end
        else if (m_seq.size() == 2 && m_seq[0] == 8'hE0) begin dir = arrow_idx(m_seq[1]); mk = 1'b1; end
        else if (m_seq.size() == 2) dir = wasd_idx(m_seq[1]);
        else dir = arrow_idx(m_seq[2]);
        m_seq.delete();
      end
      if (dir >= 0) begin
        if (mk && !m_held[dir]) begin
          m_held[dir] = 1'b1; m_pend[dir] = 1'b1; m_age[dir] = 0; m_reps[dir] = 0;
        end else if (!mk) begin
          m_held[dir] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic t);
    @(negedge clock);
    key_valid = v; key_data = d; frame_tick = t;
    if (t) tick_no++;
    model_step(v, d, t);
    @(posedge clock); #1;
    exp_move = nxt_move;
    exp_held = m_held;
    check_en = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic clear_hits();
    tick_no = 0;
    hits_up.delete(); hits_down.delete(); hits_left.delete(); hits_right.delete();
  endtask

  task automatic check_list(input string name, input int got[$], input int want[$]);
    vectors++;
    if (got.size() != want.size()) begin
      misc++;
      $display("FAIL %s: got %0d pulses %p, required %0d pulses %p", name, got.size(), got,
               want.size(), want);
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        if (got[i] != want[i]) begin
          misc++;
          $display("FAIL %s: pulse %0d on tick %0d, required tick %0d", name, i, got[i], want[i]);
          break;
        end
      end
    end
  endtask

  task automatic check_held(input string name, input logic [3:0] want);
    vectors++;
    if (held !== want) begin
      misc++;
      $display("FAIL %s: held=%b required %b", name, held, want);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      vectors++;
      if ({move_right, move_left, move_down, move_up} !== exp_move) begin
        misc++;
        $display("FAIL move @%0t: got %b required %b", $time,
                 {move_right, move_left, move_down, move_up}, exp_move);
      end
      vectors++;
      if (held !== exp_held) begin
        misc++;
        $display("FAIL held @%0t: got %b required %b", $time, held, exp_held);
      end
      if (move_up)    hits_up.push_back(tick_no);
      if (move_down)  hits_down.push_back(tick_no);
      if (move_left)  hits_left.push_back(tick_no);
      if (move_right) hits_right.push_back(tick_no);
    end
  end

  initial begin
    int want[$];
    int none[$];
    reset = 1'b1; key_valid = 1'b0; key_data = 8'h00; frame_tick = 1'b0; enable = 1'b1;
    model_reset();
    #3;
    vectors++;
    if ({move_right, move_left, move_down, move_up, held} !== 8'h00) begin
      misc++;
      $display("FAIL reset_state: got %b required 00000000",
               {move_right, move_left, move_down, move_up, held});
    end
    @(negedge clock); reset = 1'b0;

    // Tap shorter than a frame: exactly one move on the next tick.
    clear_hits();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    tick(3);
    want = '{1};
    check_list("tap_up", hits_up, want);
    check_held("tap_held", 4'b0000);

    // Hold right: first move, delay of 15 frames, then every 4 frames.
    clear_hits();
    send(8'hE0); send(8'h74);
    tick(40);
    want = '{1, 16, 20, 24, 28, 32, 36, 40};
    check_list("hold_right", hits_right, want);
    check_held("hold_held", 4'b1000);
    send(8'hE0); send(8'hF0); send(8'h74);
    tick(2);

    // Typematic resends while held must not restart the schedule.
    clear_hits();
    send(8'hE0); send(8'h74);
    for (int i = 0; i < 40; i++) begin
      if (i < 9) begin send(8'hE0); send(8'h74); end
      tick(1);
    end
    want = '{1, 16, 20, 24, 28, 32, 36, 40};
    check_list("resend_right", hits_right, want);
    send(8'hE0); send(8'hF0); send(8'h74);
    tick(2);

    // Opposing up/down cancel; after releasing down, up follows its own counter.
    clear_hits();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
    tick(5);
    send(8'hE0); send(8'hF0); send(8'h72);
    tick(15);
    want = '{16, 20};
    check_list("opp_up", hits_up, want);
    check_list("opp_down", hits_down, none);
    check_held("opp_held", 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    tick(2);

    // Disabled tick consumes the pending tap.
    clear_hits();
    enable = 1'b0;
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    tick(1);
    enable = 1'b1;
    tick(3);
    check_list("enable_left", hits_left, none);

    // Key on the same cycle as a tick only affects the following tick.
    clear_hits();
    send(8'hE0);
    cyc(1'b1, 8'h75, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    tick(2);
    want = '{2};
    check_list("same_cycle_up", hits_up, want);
    send(8'hE0); send(8'hF0); send(8'h75);
    tick(2);

    // Reset mid-sequence after E0 F0.
    clear_hits();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0);
    reset = 1'b1;
    #1;
    check_held("reset_mid_held", 4'b0000);
    vectors++;
    if ({move_right, move_left, move_down, move_up} !== 4'b0000) begin
      misc++;
      $display("FAIL reset_mid_move: got %b required 0000",
               {move_right, move_left, move_down, move_up});
    end
    model_reset();
    exp_move = 4'b0; exp_held = 4'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    send(8'h75);
    tick(2);
    check_list("reset_then_75", hits_up, none);
    check_held("reset_then_75_held", 4'b0000);
`ifdef PS2_MOVE_WASD_EN
    clear_hits();
    send(8'h1D);
    check_held("wasd_w_held", 4'b0001);
    tick(1);
    want = '{1};
    check_list("wasd_w_move", hits_up, want);
    send(8'hF0); send(8'h1D);
    tick(1);
    check_held("wasd_w_break", 4'b0000);
`endif

    @(negedge clock);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
